// File: rtl/calc_seq.sv
// Calculator command sequencer: builds decimal operands from key strobes and runs
// add, subtract and shift-add multiply on one shared adder for the display stage.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ENTER_A | collecting first operand digits into acc
// S_ENTER_B | operator latched, collecting second operand digits into acc
// S_EXEC    | add/sub for one cycle, or multiply for W shift-add cycles
// S_RESULT  | result shown; digit starts fresh, operator chains on result
// S_ERROR   | overflow; only clear leaves this state
module calc_seq #(
   parameter int DIGITS = 8,
   parameter int W      = 27
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [3:0]   cmd,
   input  logic         cmd_valid,
   output logic [W-1:0] value,
   output logic         neg,
   output logic [1:0]   status,
   output logic         busy
);

   localparam logic [63:0]     MAXVAL_L  = (64'd10 ** DIGITS) - 64'd1;
   localparam logic [W:0]      MAXVAL_S  = MAXVAL_L[W:0];
   localparam logic [2*W-1:0]  MAXVAL_P  = MAXVAL_L[2*W-1:0];
   localparam int              CW        = $clog2(W) + 1;
   localparam int              DW        = $clog2(DIGITS + 1);
   localparam logic [CW-1:0]   MUL_LOAD  = CW'(W);
   localparam logic [CW-1:0]   MUL_LAST  = CW'(1);
   localparam logic [DW-1:0]   DIG_MAX   = DW'(DIGITS);

   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;
   localparam logic [1:0] OP_MUL = 2'b00;

   localparam logic [1:0] ST_ENTRY  = 2'b00;
   localparam logic [1:0] ST_BUSY   = 2'b01;
   localparam logic [1:0] ST_ERROR  = 2'b10;
   localparam logic [1:0] ST_RESULT = 2'b11;

   typedef enum logic [2:0] {
      S_ENTER_A,
      S_ENTER_B,
      S_EXEC,
      S_RESULT,
      S_ERROR
   } state_t;

   state_t          state;
   logic [W-1:0]    acc;
   logic [W-1:0]    a;
   logic [W-1:0]    res;
   logic [1:0]      op;
   logic [DW-1:0]   dcnt;
   logic [CW-1:0]   mcnt;
   logic [2*W-1:0]  prod;

   logic            is_digit;
   logic            is_op;
   logic            is_eq;
   logic            is_clr;
   logic [W-1:0]    acc_dig;
   logic [W-1:0]    digit_w;

   logic [W-1:0]    add_x;
   logic [W-1:0]    add_y;
   logic            add_inv;
   logic [W:0]      add_sum;
   logic            sub_swap;
   logic [W:0]      hi_next;
   logic [2*W-1:0]  prod_step;

   logic            exec_done;
   logic            exec_ovf;
   logic [W-1:0]    exec_val;
   logic            exec_neg;

   always_comb begin
      is_digit = cmd_valid && (cmd < 4'd10);
      is_op    = cmd_valid && ((cmd == 4'b1010) || (cmd == 4'b1011) || (cmd == 4'b1100));
      is_eq    = cmd_valid && (cmd == 4'b1110);
      is_clr   = cmd_valid && (cmd == 4'b1111);
      digit_w  = {{(W-4){1'b0}}, cmd};
      acc_dig  = {acc[W-4:0], 3'b000} + {acc[W-2:0], 1'b0} + digit_w;
   end

   // One adder serves add, the |a-b| subtract and each multiply partial sum.
   always_comb begin
      sub_swap = (a < acc);
      add_x    = a;
      add_y    = acc;
      add_inv  = 1'b0;
      if (op == OP_MUL) begin
         add_x = prod[2*W-1:W];
         add_y = a;
      end else if (op == OP_SUB) begin
         add_inv = 1'b1;
         if (sub_swap) begin
            add_x = acc;
            add_y = a;
         end
      end
      add_sum   = {1'b0, add_x} + {1'b0, (add_inv ? ~add_y : add_y)} + {{W{1'b0}}, add_inv};
      hi_next   = prod[0] ? add_sum : {1'b0, prod[2*W-1:W]};
      prod_step = {hi_next, prod[W-1:1]};
   end

   always_comb begin
      exec_done = 1'b0;
      exec_ovf  = 1'b0;
      exec_val  = add_sum[W-1:0];
      exec_neg  = 1'b0;
      case (op)
         OP_MUL: begin
            exec_done = (mcnt == MUL_LAST);
            exec_ovf  = (prod_step > MAXVAL_P);
            exec_val  = prod_step[W-1:0];
         end
         OP_SUB: begin
            exec_done = 1'b1;
            exec_neg  = sub_swap;
         end
         default: begin
            exec_done = 1'b1;
            exec_ovf  = (add_sum > MAXVAL_S);
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || is_clr) begin
         state  <= S_ENTER_A;
         acc    <= '0;
         a      <= '0;
         res    <= '0;
         op     <= OP_ADD;
         dcnt   <= '0;
         mcnt   <= '0;
         prod   <= '0;
         value  <= '0;
         neg    <= 1'b0;
         status <= ST_ENTRY;
         busy   <= 1'b0;
      end else begin
         case (state)
            S_ENTER_A, S_ENTER_B: begin
               if (is_digit) begin
                  if (dcnt < DIG_MAX) begin
                     acc   <= acc_dig;
                     dcnt  <= dcnt + 1'b1;
                     value <= acc_dig;
                  end
               end else if (is_op) begin
                  op <= cmd[1:0];
                  if (state == S_ENTER_A) begin
                     a     <= acc;
                     acc   <= '0;
                     dcnt  <= '0;
                     value <= '0;
                     state <= S_ENTER_B;
                  end
               end else if (is_eq && (state == S_ENTER_B)) begin
                  prod   <= {{W{1'b0}}, acc};
                  mcnt   <= MUL_LOAD;
                  value  <= '0;
                  status <= ST_BUSY;
                  busy   <= 1'b1;
                  state  <= S_EXEC;
               end
            end

            S_EXEC: begin
               if (op == OP_MUL) begin
                  prod <= prod_step;
                  mcnt <= mcnt - 1'b1;
               end
               if (exec_done) begin
                  busy <= 1'b0;
                  if (exec_ovf) begin
                     res    <= '0;
                     value  <= '0;
                     neg    <= 1'b0;
                     status <= ST_ERROR;
                     state  <= S_ERROR;
                  end else begin
                     res    <= exec_val;
                     value  <= exec_val;
                     neg    <= exec_neg;
                     status <= ST_RESULT;
                     state  <= S_RESULT;
                  end
               end
            end

            S_RESULT: begin
               if (is_digit) begin
                  acc    <= digit_w;
                  dcnt   <= DW'(1);
                  value  <= digit_w;
                  neg    <= 1'b0;
                  status <= ST_ENTRY;
                  state  <= S_ENTER_A;
               end else if (is_op && !neg) begin
                  a      <= res;
                  op     <= cmd[1:0];
                  acc    <= '0;
                  dcnt   <= '0;
                  value  <= '0;
                  status <= ST_ENTRY;
                  state  <= S_ENTER_B;
               end
            end

            S_ERROR: begin
            end

            default: begin
               state  <= S_ENTER_A;
               status <= ST_ENTRY;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: directed key sequences plus random keys checked against
// an arithmetic model of the calculator.
module tb_calc_seq;
   localparam int W = 27;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   cmd;
   logic         cmd_valid;
   logic [W-1:0] value;
   logic         neg;
   logic [1:0]   status;
   logic         busy;

   int total = 0;
   int bad   = 0;

   // model state: 0 entering A, 1 entering B, 2 result, 3 error
   int      mmode;
   longint  macc, ma, mres;
   int      mcount, mop;
   bit      mneg;

   calc_seq #(.DIGITS(8), .W(W)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .value(value), .neg(neg), .status(status), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] k);
      cmd = k; cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0; cmd = 4'd0;
   endtask

   task automatic press(input logic [3:0] k, output int lat);
      pulse(k);
      lat = 0;
      while (busy === 1'b1 && lat < 200) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic model_clear();
      mmode = 0; macc = 0; ma = 0; mres = 0; mcount = 0; mop = 10; mneg = 0;
   endtask

   task automatic model_key(input int k, output int elat);
      longint r;
      elat = 0;
      if (k == 15) begin
         model_clear();
      end else if (k != 13) begin
         if (mmode == 0 || mmode == 1) begin
            if (k < 10) begin
               if (mcount < 8) begin macc = macc * 10 + k; mcount++; end
            end else if (k >= 10 && k <= 12) begin
               if (mmode == 0) begin ma = macc; macc = 0; mcount = 0; mmode = 1; end
               mop = k;
            end else if (k == 14 && mmode == 1) begin
               elat = (mop == 12) ? 27 : 1;
               mneg = 0;
               if (mop == 10) r = ma + macc;
               else if (mop == 12) r = ma * macc;
               else if (ma >= macc) r = ma - macc;
               else begin r = macc - ma; mneg = 1; end
               if (r > 99999999) begin mmode = 3; mres = 0; mneg = 0; end
               else begin mmode = 2; mres = r; end
            end
         end else if (mmode == 2) begin
            if (k < 10) begin
               macc = k; mcount = 1; mmode = 0; mneg = 0;
            end else if (k >= 10 && k <= 12 && !mneg) begin
               ma = mres; mop = k; macc = 0; mcount = 0; mmode = 1;
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (value !== '0) begin bad++; $display("FAIL reset_value got=%0d want=0", value); end
      total++; if (status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", status); end
      total++; if (neg !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags got neg=%b busy=%b want 0 0", neg, busy); end
   endtask

   task automatic test_add_sub();
      int lat;
      press(4'd5, lat); press(4'd0, lat);
      total++; if (value !== 27'd50 || status !== 2'b00) begin bad++; $display("FAIL entry50 got=%0d st=%b want=50 st=00", value, status); end
      press(4'd11, lat); press(4'd1, lat); press(4'd5, lat);
      total++; if (value !== 27'd15) begin bad++; $display("FAIL entry15 got=%0d want=15", value); end
      press(4'd14, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL sub_latency got=%0d want=1", lat); end
      total++; if (value !== 27'd35 || neg !== 1'b0 || status !== 2'b11) begin bad++; $display("FAIL sub35 got=%0d neg=%b st=%b want=35 0 11", value, neg, status); end
      do_reset();
      press(4'd1, lat); press(4'd11, lat); press(4'd5, lat); press(4'd14, lat);
      total++; if (value !== 27'd4 || neg !== 1'b1 || status !== 2'b11) begin bad++; $display("FAIL sub_neg got=%0d neg=%b st=%b want=4 1 11", value, neg, status); end
      press(4'd10, lat);
      total++; if (value !== 27'd4 || status !== 2'b11) begin bad++; $display("FAIL neg_op_ignored got=%0d st=%b want=4 11", value, status); end
      press(4'd3, lat);
      total++; if (value !== 27'd3 || status !== 2'b00 || neg !== 1'b0) begin bad++; $display("FAIL result_digit got=%0d st=%b neg=%b want=3 00 0", value, status, neg); end
   endtask

   task automatic test_mul();
      int lat;
      do_reset();
      press(4'd6, lat); press(4'd12, lat); press(4'd2, lat); press(4'd14, lat);
      total++; if (lat !== 27) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=27", lat); end
      total++; if (value !== 27'd12 || status !== 2'b11) begin bad++; $display("FAIL mul12 got=%0d st=%b want=12 11", value, status); end
   endtask

   task automatic test_overflow();
      int lat;
      do_reset();
      repeat (9) press(4'd9, lat);
      total++; if (value !== 27'd99999999) begin bad++; $display("FAIL digit_limit got=%0d want=99999999", value); end
      press(4'd10, lat); press(4'd1, lat); press(4'd14, lat);
      total++; if (status !== 2'b10 || value !== '0 || neg !== 1'b0) begin bad++; $display("FAIL add_ovf got=%0d st=%b neg=%b want=0 10 0", value, status, neg); end
      press(4'd7, lat);
      total++; if (status !== 2'b10 || value !== '0) begin bad++; $display("FAIL error_hold got=%0d st=%b want=0 10", value, status); end
      press(4'd15, lat);
      total++; if (status !== 2'b00 || value !== '0) begin bad++; $display("FAIL error_clear got=%0d st=%b want=0 00", value, status); end
   endtask

   task automatic test_exec_abort();
      int lat;
      int n;
      do_reset();
      press(4'd9, lat); press(4'd9, lat); press(4'd9, lat); press(4'd12, lat);
      press(4'd9, lat); press(4'd9, lat); press(4'd9, lat);
      pulse(4'd14);
      total++; if (busy !== 1'b1 || status !== 2'b01) begin bad++; $display("FAIL exec_enter got busy=%b st=%b want 1 01", busy, status); end
      repeat (5) @(negedge clock);
      pulse(4'd10);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL exec_drop_busy got=%b want=1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 200) begin @(negedge clock); n++; end
      total++; if (n !== 21) begin bad++; $display("FAIL exec_remaining got=%0d want=21", n); end
      total++; if (value !== 27'd998001 || status !== 2'b11) begin bad++; $display("FAIL mul999 got=%0d st=%b want=998001 11", value, status); end
      do_reset();
      press(4'd9, lat); press(4'd9, lat); press(4'd9, lat); press(4'd12, lat);
      press(4'd9, lat); press(4'd9, lat); press(4'd9, lat);
      pulse(4'd14);
      repeat (3) @(negedge clock);
      pulse(4'd15);
      total++; if (status !== 2'b00 || busy !== 1'b0 || value !== '0) begin bad++; $display("FAIL exec_clear got=%0d st=%b busy=%b want=0 00 0", value, status, busy); end
      press(4'd4, lat); press(4'd14, lat);
      total++; if (value !== 27'd4 || status !== 2'b00 || lat !== 0) begin bad++; $display("FAIL after_clear got=%0d st=%b lat=%0d want=4 00 0", value, status, lat); end
   endtask

   task automatic test_reset_priority_chain();
      int lat;
      do_reset();
      press(4'd1, lat); press(4'd2, lat);
      cmd = 4'd3; cmd_valid = 1'b1; reset = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0; reset = 1'b0;
      total++; if (value !== '0 || status !== 2'b00) begin bad++; $display("FAIL reset_wins got=%0d st=%b want=0 00", value, status); end
      press(4'd2, lat); press(4'd12, lat); press(4'd3, lat); press(4'd14, lat);
      total++; if (value !== 27'd6) begin bad++; $display("FAIL chain_mul got=%0d want=6", value); end
      press(4'd10, lat); press(4'd4, lat); press(4'd14, lat);
      total++; if (value !== 27'd10 || status !== 2'b11 || lat !== 1) begin bad++; $display("FAIL chain_add got=%0d st=%b lat=%0d want=10 11 1", value, status, lat); end
   endtask

   task automatic test_random();
      int r, k, lat, elat, est;
      longint ev;
      logic [W-1:0] evw;
      do_reset();
      model_clear();
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55) k = $urandom_range(0, 9);
         else if (r < 63) k = 10;
         else if (r < 71) k = 11;
         else if (r < 80) k = 12;
         else if (r < 91) k = 14;
         else if (r < 94) k = 13;
         else k = 15;
         model_key(k, elat);
         press(4'(k), lat);
         ev  = (mmode <= 1) ? macc : ((mmode == 2) ? mres : 0);
         evw = ev[W-1:0];
         est = (mmode <= 1) ? 0 : ((mmode == 2) ? 3 : 2);
         total++;
         if (value !== evw || status !== 2'(est) || neg !== (mmode == 2 && mneg) || lat !== elat || busy !== 1'b0) begin
            bad++;
            $display("FAIL rand_%0d key=%0d got val=%0d st=%b neg=%b lat=%0d want val=%0d st=%0d neg=%0d lat=%0d",
                     i, k, value, status, neg, lat, ev, est, (mmode == 2 && mneg), elat);
         end
      end
   endtask

   initial begin
      reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
      test_reset();
      test_add_sub();
      test_mul();
      test_overflow();
      test_exec_abort();
      test_reset_priority_chain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
